// File: rtl/mem_preloader.sv
// Byte-stream frame loader for data_memory's preload port: assembles LE words
// from an address/count/data frame and issues one pre_ld strobe per word.
module mem_preloader #(
  parameter int N       = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        pre_ld,
  output logic [31:0] pre_A,
  output logic [31:0] pre_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_CNT   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   base_q, base_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [31:0]   buf_q, buf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   pre_a_q, pre_a_d;
  logic [31:0]   pre_data_q, pre_data_d;

  logic        accept;
  logic        last_word;
  logic [32:0] end_addr;

  assign in_ready = (state_q == S_ADDR) || (state_q == S_CNT) || (state_q == S_DATA);
  assign busy     = in_ready || (state_q == S_WRITE);
  assign pre_ld   = (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign pre_A    = pre_a_q;
  assign pre_data = pre_data_q;
  assign accept   = in_ready && in_valid;

  assign last_word = (({1'b0, word_idx_q} + 17'd1) == {1'b0, count_q});

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    base_d     = base_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    buf_d      = buf_q;
    pre_a_d    = pre_a_q;
    pre_data_d = pre_data_q;
    tmo_d      = '0;
    end_addr   = '0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_ADDR;
          byte_idx_d = 2'd0;
        end
      end
      S_ADDR: begin
        if (accept) begin
          base_d[{byte_idx_q, 3'b000} +: 8] = in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = (base_d[1:0] != 2'b00) ? S_ERR : S_CNT;
          end
        end
      end
      S_CNT: begin
        if (accept) begin
          count_d[{byte_idx_q[0], 3'b000} +: 8] = in_data;
          if (byte_idx_q[0]) begin
            byte_idx_d = 2'd0;
            // 33-bit sum so a base near the top of the address space cannot wrap past the check
            end_addr   = {1'b0, base_q} + {15'd0, count_d, 2'b00};
            if (count_d == 16'd0) begin
              state_d = S_DONE;
            end else if (end_addr > 33'(N)) begin
              state_d = S_ERR;
            end else begin
              state_d    = S_DATA;
              word_idx_d = 16'd0;
            end
          end else begin
            byte_idx_d = 2'd1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          buf_d[{byte_idx_q, 3'b000} +: 8] = in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d    = S_WRITE;
            pre_a_d    = base_q + {14'd0, word_idx_q, 2'b00};
            pre_data_d = buf_d;
          end
        end
      end
      S_WRITE: begin
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_DATA;
          word_idx_d = word_idx_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stall watchdog: only byte-accepting states count idle cycles
    if (in_ready && !accept) begin
      if (tmo_q >= TW'(TIMEOUT - 1)) begin
        state_d = S_ERR;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      base_q     <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      buf_q      <= '0;
      tmo_q      <= '0;
      pre_a_q    <= '0;
      pre_data_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      base_q     <= base_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      buf_q      <= buf_d;
      tmo_q      <= tmo_d;
      pre_a_q    <= pre_a_d;
      pre_data_q <= pre_data_d;
    end
  end

endmodule
